// File: rtl/crc8_serial_checker.sv
// Serial CRC-8 receive checker: recomputes CRC over payload, checks trailer, deserialises bytes.
// Optional macro CRC_ERR_CNT_EN adds the saturating ERR_CNT output.
module crc8_serial_checker #(
  parameter logic [7:0] SEED  = 8'h8E,
  parameter int         CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SER_DATA,
  input  logic             SER_ACTIVE,
  input  logic             CRC_BIT,
  input  logic             CRC_VALID,
  output logic [7:0]       BYTE_OUT,
  output logic             BYTE_VLD,
  output logic [CNT_W-1:0] PAY_BITS,
  output logic             FRAME_DONE,
  output logic             CRC_OK,
  output logic             CRC_ERR,
`ifdef CRC_ERR_CNT_EN
  output logic [7:0]       ERR_CNT,
`endif
  output logic             PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    TRAILER,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  logic [7:0]       lfsr_q;
  logic [7:0]       sr_q;
  logic [2:0]       bidx_q;
  logic [2:0]       tcnt_q;
  logic             mis_q;
  logic [CNT_W-1:0] pay_q;
  logic [7:0]       byte_q;
  logic             bvld_q;
  logic             done_q;
  logic             ok_q;
  logic             err_q;
  logic             perr_q;

  logic [7:0]       src;
  logic             fb;
  logic [7:0]       lfsr_d;
  logic [7:0]       sr_d;
  logic [CNT_W-1:0] pay_d;
  logic [7:0]       tsrc;
  logic [2:0]       tidx;
  logic             tmis;
  logic             clash;
  logic             start;

  // Next LFSR/byte/count values and trailer-bit compare for this cycle
  always_comb begin
    src    = (state_q == PAYLOAD) ? lfsr_q : SEED;
    fb     = src[0] ^ SER_DATA;
    lfsr_d = {fb, src[7] ^ fb, src[6:4], src[3] ^ fb, src[2:1]};
    sr_d   = {SER_DATA, sr_q[7:1]};
    pay_d  = (&pay_q) ? pay_q : pay_q + ONE;
    tsrc   = (state_q == IDLE) ? SEED : lfsr_q;
    tidx   = (state_q == TRAILER) ? tcnt_q : 3'd0;
    tmis   = CRC_BIT ^ tsrc[tidx];
    clash  = SER_ACTIVE & CRC_VALID;
    start  = SER_ACTIVE & ~CRC_VALID & (state_q != PAYLOAD);
  end

  // Frame FSM with registered strobes and datapath
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      sr_q    <= 8'h00;
      bidx_q  <= 3'd0;
      tcnt_q  <= 3'd0;
      mis_q   <= 1'b0;
      pay_q   <= '0;
      byte_q  <= 8'h00;
      bvld_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      bvld_q <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      perr_q <= 1'b0;
      if (clash) begin
        perr_q  <= 1'b1;
        state_q <= IDLE;
      end else if (start) begin
        perr_q  <= (state_q == TRAILER);
        lfsr_q  <= lfsr_d;
        sr_q    <= sr_d;
        pay_q   <= ONE;
        bidx_q  <= 3'd1;
        tcnt_q  <= 3'd0;
        mis_q   <= 1'b0;
        state_q <= PAYLOAD;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (CRC_VALID) begin
              lfsr_q  <= SEED;
              pay_q   <= '0;
              tcnt_q  <= 3'd1;
              mis_q   <= tmis;
              state_q <= TRAILER;
            end
          end
          PAYLOAD: begin
            if (SER_ACTIVE) begin
              lfsr_q <= lfsr_d;
              sr_q   <= sr_d;
              pay_q  <= pay_d;
              bidx_q <= bidx_q + 3'd1;
              if (bidx_q == 3'd7) begin
                byte_q <= sr_d;
                bvld_q <= 1'b1;
              end
            end else if (CRC_VALID) begin
              tcnt_q  <= 3'd1;
              mis_q   <= tmis;
              state_q <= TRAILER;
            end
          end
          TRAILER: begin
            if (CRC_VALID) begin
              tcnt_q <= tcnt_q + 3'd1;
              mis_q  <= mis_q | tmis;
              if (tcnt_q == 3'd7) begin
                done_q  <= 1'b1;
                ok_q    <= ~(mis_q | tmis);
                err_q   <= mis_q | tmis;
                state_q <= DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CRC_ERR_CNT_EN
  logic [7:0] ecnt_q;

  // Saturating count of CRC and framing error strobes
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ecnt_q <= 8'h00;
    end else if ((err_q | perr_q) && ecnt_q != 8'hFF) begin
      ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign ERR_CNT = ecnt_q;
`endif

  assign BYTE_OUT   = byte_q;
  assign BYTE_VLD   = bvld_q;
  assign PAY_BITS   = pay_q;
  assign FRAME_DONE = done_q;
  assign CRC_OK     = ok_q;
  assign CRC_ERR    = err_q;
  assign PROTO_ERR  = perr_q;

endmodule

// File: tb/tb_crc8_serial_checker.sv
// Directed testbench for crc8_serial_checker.
// Frame table plus hand sequences for abort, reset and trailer corner cases.
module tb_crc8_serial_checker;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             SER_DATA = 1'b0;
  logic             SER_ACTIVE = 1'b0;
  logic             CRC_BIT = 1'b0;
  logic             CRC_VALID = 1'b0;
  logic [7:0]       BYTE_OUT;
  logic             BYTE_VLD;
  logic [CNT_W-1:0] PAY_BITS;
  logic             FRAME_DONE;
  logic             CRC_OK;
  logic             CRC_ERR;
  logic             PROTO_ERR;
`ifdef CRC_ERR_CNT_EN
  logic [7:0]       ERR_CNT;
`endif

  crc8_serial_checker #(.SEED(8'h8E), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SER_DATA  (SER_DATA),
    .SER_ACTIVE(SER_ACTIVE),
    .CRC_BIT   (CRC_BIT),
    .CRC_VALID (CRC_VALID),
    .BYTE_OUT  (BYTE_OUT),
    .BYTE_VLD  (BYTE_VLD),
    .PAY_BITS  (PAY_BITS),
    .FRAME_DONE(FRAME_DONE),
    .CRC_OK    (CRC_OK),
    .CRC_ERR   (CRC_ERR),
`ifdef CRC_ERR_CNT_EN
    .ERR_CNT   (ERR_CNT),
`endif
    .PROTO_ERR (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          nbits;
    logic [15:0] pay;
    logic [7:0]  trl;
    bit          gaps;
    bit          ok;
    int          nbytes;
    logic [7:0]  b0;
  } vec_t;

  vec_t tbl [7];

  int n_cmp = 0;
  int n_bad = 0;
  int nb_vld, nb_done, nb_ok, nb_err, nb_perr;
  logic [7:0] first_byte;
  bit got_byte;

  function automatic logic [7:0] crc_model(int n, logic [15:0] p);
    logic [7:0] l;
    logic f;
    l = 8'h8E;
    for (int i = 0; i < n; i++) begin
      f = l[0] ^ p[i];
      l = {f, l[7] ^ f, l[6], l[5], l[4], l[3] ^ f, l[2], l[1]};
    end
    return l;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    nb_vld = 0; nb_done = 0; nb_ok = 0; nb_err = 0; nb_perr = 0;
    got_byte = 0; first_byte = 8'h00;
  endtask

  task automatic cyc(bit sa, bit sd, bit cv, bit cb);
    SER_ACTIVE = sa; SER_DATA = sd; CRC_VALID = cv; CRC_BIT = cb;
    @(posedge CLK);
    #1;
    if (BYTE_VLD) begin
      if (!got_byte) first_byte = BYTE_OUT;
      got_byte = 1;
      nb_vld++;
    end
    nb_done += int'(FRAME_DONE);
    nb_ok   += int'(CRC_OK);
    nb_err  += int'(CRC_ERR);
    nb_perr += int'(PROTO_ERR);
  endtask

  task automatic send_trl(logic [7:0] t, int from, int to);
    for (int j = from; j <= to; j++) begin
      cyc(0, 0, 1, t[j]);
      if (j == 7) chk("done_lat", FRAME_DONE, 1);
    end
  endtask

  task automatic run_frame(int k);
    vec_t v;
    v = tbl[k];
    clr();
    for (int i = 0; i < v.nbits; i++) begin
      cyc(1, v.pay[i], 0, 0);
      if (i == 7) chk("byte_lat", BYTE_VLD, 1);
      if (v.gaps) cyc(0, 0, 0, 0);
    end
    for (int j = 0; j < 8; j++) begin
      cyc(0, 0, 1, v.trl[j]);
      if (j == 7) chk("done_lat", FRAME_DONE, 1);
      if (v.gaps && j < 7) cyc(0, 0, 0, 0);
    end
    repeat (3) cyc(0, 0, 0, 0);
    chk($sformatf("f%0d_done", k), nb_done, 1);
    chk($sformatf("f%0d_ok", k), nb_ok, v.ok ? 1 : 0);
    chk($sformatf("f%0d_err", k), nb_err, v.ok ? 0 : 1);
    chk($sformatf("f%0d_perr", k), nb_perr, 0);
    chk($sformatf("f%0d_nbytes", k), nb_vld, v.nbytes);
    chk($sformatf("f%0d_paybits", k), PAY_BITS, v.nbits);
    if (v.nbytes > 0) chk($sformatf("f%0d_byte0", k), first_byte, v.b0);
  endtask

  initial begin
    tbl[0] = '{0,  16'h0000, 8'h8E, 0, 1, 0, 8'h00};
    tbl[1] = '{1,  16'h0001, 8'h83, 0, 1, 0, 8'h00};
    tbl[2] = '{8,  16'h0000, 8'h42, 0, 1, 1, 8'h00};
    tbl[3] = '{8,  16'h0000, 8'h4A, 0, 0, 1, 8'h00};
    tbl[4] = '{16, 16'h5AA5, crc_model(16, 16'h5AA5), 0, 1, 2, 8'hA5};
    tbl[5] = '{12, 16'h03C3, crc_model(12, 16'h03C3), 0, 1, 1, 8'hC3};
    tbl[6] = '{16, 16'h3C96, crc_model(16, 16'h3C96), 1, 1, 2, 8'h96};

    #2 RST = 1'b0;
    #1;
    chk("rst_paybits", PAY_BITS, 0);
    chk("rst_strobes", {BYTE_VLD, FRAME_DONE, CRC_OK, CRC_ERR, PROTO_ERR}, 0);
    chk("rst_byte", BYTE_OUT, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;

    for (int k = 0; k < 7; k++) run_frame(k);

    // clash mid-payload aborts to IDLE
    clr();
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    chk("clash_perr", PROTO_ERR, 1);
    chk("clash_nodone", FRAME_DONE, 0);
    cyc(0, 0, 0, 0);
    chk("clash_perr_1cyc", PROTO_ERR, 0);
    send_trl(8'h8E, 0, 7);
    chk("clash_idle_ok", CRC_OK, 1);
    chk("clash_idle_pay", PAY_BITS, 0);
    repeat (2) cyc(0, 0, 0, 0);
    chk("clash_ndone", nb_done, 1);

    // payload bit during trailer restarts frame
    clr();
    cyc(1, 1, 0, 0);
    send_trl(8'h83, 0, 3);
    cyc(1, 1, 0, 0);
    chk("trl_abort_perr", PROTO_ERR, 1);
    send_trl(8'h83, 0, 7);
    chk("trl_abort_ok", CRC_OK, 1);
    for (int j = 0; j < 10; j++) cyc(0, 0, 1, j[0]);
    repeat (2) cyc(0, 0, 0, 0);
    chk("hold_cv_ndone", nb_done, 1);
    chk("hold_cv_nperr", nb_perr, 1);
    chk("hold_cv_nerr", nb_err, 0);
    chk("hold_cv_pay", PAY_BITS, 1);

`ifdef CRC_ERR_CNT_EN
    @(negedge CLK) RST = 1'b0;
    @(negedge CLK) RST = 1'b1;
    chk("ecnt_rst", ERR_CNT, 0);
    for (int r = 0; r < 3; r++) run_frame(3);
    chk("ecnt_3", ERR_CNT, 3);
`endif

    // asynchronous reset mid-trailer
    clr();
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    send_trl(8'h42, 0, 2);
    #3 RST = 1'b0;
    #1;
    chk("mid_rst_pay", PAY_BITS, 0);
    chk("mid_rst_strb", {BYTE_VLD, FRAME_DONE, CRC_OK, CRC_ERR, PROTO_ERR}, 0);
    chk("mid_rst_byte", BYTE_OUT, 0);
`ifdef CRC_ERR_CNT_EN
    chk("mid_rst_ecnt", ERR_CNT, 0);
`endif
    @(negedge CLK) RST = 1'b1;
    clr();
    send_trl(8'h8E, 0, 7);
    chk("post_rst_ok", CRC_OK, 1);
    repeat (2) cyc(0, 0, 0, 0);
    chk("post_rst_nerr", nb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc8_serial_checker.md
Name: crc8_serial_checker

Overview:
Receive-side companion to the serial CRC-8 generator. Consumes the generator's serial stream: payload bits qualified by SER_ACTIVE, then an 8-bit CRC trailer qualified by CRC_VALID. Recomputes the CRC over the payload, compares it with the received trailer, reports pass/fail per frame, and deserialises the payload into bytes for the downstream byte consumer.

Parameters:
SEED, 8'h8E, LFSR initial value loaded at reset and at every frame start
CNT_W, 16, width of the payload bit counter PAY_BITS

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
SER_DATA  in  1  payload bit, valid when SER_ACTIVE=1
SER_ACTIVE  in  1  payload bit qualifier
CRC_BIT  in  1  trailer bit, valid when CRC_VALID=1, LFSR[0] of generator first
CRC_VALID  in  1  trailer bit qualifier; may stay high after the trailer
BYTE_OUT  out  8  assembled payload byte, first received bit in bit 0
BYTE_VLD  out  1  one-cycle strobe, BYTE_OUT valid
PAY_BITS  out  CNT_W  payload bits in the current/last frame, saturating
FRAME_DONE  out  1  one-cycle strobe at end of trailer
CRC_OK  out  1  one-cycle strobe with FRAME_DONE, trailer matched
CRC_ERR  out  1  one-cycle strobe with FRAME_DONE, trailer mismatched
PROTO_ERR  out  1  one-cycle strobe, framing violation

Behaviour:
- Reset (RST=0, async): state IDLE, LFSR=SEED, all outputs 0, counters 0.
- CRC step per payload bit d: fb=LFSR[0]^d; next LFSR = {fb, LFSR[7]^fb, LFSR[6], LFSR[5], LFSR[4], LFSR[3]^fb, LFSR[2], LFSR[1]}.
- States: IDLE, PAYLOAD, TRAILER, DONE.
- IDLE/DONE: SER_ACTIVE=1 -> LFSR reloaded with SEED, then stepped with SER_DATA in the same cycle; PAY_BITS=1, byte bit index=1; go PAYLOAD. CRC_VALID alone in IDLE -> go TRAILER with 0 payload bits (LFSR=SEED); CRC_VALID in DONE is ignored.
- PAYLOAD: each SER_ACTIVE cycle steps the LFSR, shifts SER_DATA into byte assembly register, increments PAY_BITS (saturating at all-ones). On 8th bit, BYTE_OUT/BYTE_VLD registered next cycle (1-cycle latency), index wraps to 0. SER_ACTIVE=0 & CRC_VALID=0 -> stay (gaps allowed). SER_ACTIVE=0 & CRC_VALID=1 -> this cycle is trailer bit 0, go TRAILER.
- Partial final byte (PAY_BITS mod 8 != 0) discarded, no BYTE_VLD, no error.
- TRAILER: LFSR frozen as snapshot; trailer bit i compared with snapshot[i]; mismatch flag sticky. 3-bit trailer counter. After 8th bit: FRAME_DONE plus exactly one of CRC_OK/CRC_ERR next cycle; go DONE. CRC_VALID=0 gaps allowed (counter holds).
- SER_ACTIVE=1 and CRC_VALID=1 same cycle, any state: PROTO_ERR pulse, frame aborted (no FRAME_DONE), go IDLE; neither bit consumed.
- SER_ACTIVE=1 in TRAILER before 8th bit: PROTO_ERR pulse, frame aborted, new frame starts with this bit as payload bit 0 (as in IDLE).
- PAY_BITS holds the last frame's value in DONE until the next frame starts.
- Reset mid-frame: immediate return to reset state, no strobes.

Optional Feature:
CRC_ERR_CNT_EN: when defined, adds output ERR_CNT [7:0]: increments on each CRC_ERR or PROTO_ERR strobe, saturates at 8'hFF, cleared only by RST. When undefined, port and logic are absent.

Test Plan:
- Reset, CRC_VALID 8 cycles with bits 0,1,1,1,0,0,0,1 (SEED, zero payload) -> FRAME_DONE=1, CRC_OK=1, PAY_BITS=0.
- Payload 1 bit '1', trailer 1,1,0,0,0,0,0,1 (8'h83) -> CRC_OK=1, PAY_BITS=1, no BYTE_VLD.
- Payload 8'h00 (8 zero bits), trailer 0,1,0,0,0,0,1,0 (8'h42) -> BYTE_VLD=1 with BYTE_OUT=8'h00 one cycle after 8th bit, CRC_OK=1; same with bit 3 of trailer flipped -> CRC_ERR=1, CRC_OK=0.
- SER_ACTIVE and CRC_VALID high together mid-payload -> PROTO_ERR=1 for one cycle, state IDLE, no FRAME_DONE.
- Trailer of 4 bits then SER_ACTIVE=1 -> PROTO_ERR pulse, new frame counted, subsequent valid frame reports CRC_OK; CRC_VALID held high after trailer -> no second FRAME_DONE.
- CRC_ERR_CNT_EN defined: 3 bad frames -> ERR_CNT=3; RST low mid-trailer -> all outputs 0, ERR_CNT=0.
